// File: rtl/wbu_pkg.sv
// Shared encodings for the write-back unit: XLEN, w_type codes and FSM states.
package wbu_pkg;
    localparam int XLEN = 32;

    localparam logic [2:0] WT_RD    = 3'd0;
    localparam logic [2:0] WT_PC4   = 3'd1;
    localparam logic [2:0] WT_STORE = 3'd2;
    localparam logic [2:0] WT_LOAD  = 3'd3;
    localparam logic [2:0] WT_CSR   = 3'd4;

    typedef enum logic {
        S_IDLE      = 1'b0,
        S_LOAD_WAIT = 1'b1
    } wbu_state_e;
endpackage

// File: rtl/wbu_load_timer.sv
// Load-wait timeout counter; expired_o flags the last permitted wait cycle with no data.
module wbu_load_timer #(
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // The increment this cycle would make the count reach LOAD_TIMEOUT.
    assign expired_o = en_i && (cnt_q == 4'(LOAD_TIMEOUT - 1));
endmodule

// File: rtl/wbu.sv
// Write-back unit: selects the rd value, drives RF/CSR write ports and retires.
// Optional WBU_INSTRET_EN adds a 64-bit writable minstret counter.
module wbu
    import wbu_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exu_valid,
    output logic            wbu_ready,
    input  logic [XLEN-1:0] rd_data,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] pc_in,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata_in,
    input  logic [2:0]      w_type,
    input  logic            ram_rvalid,
    input  logic [XLEN-1:0] ram_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            rf_release,
    output logic [4:0]      rf_release_addr,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            retire_valid,
    output logic [XLEN-1:0] retire_pc,
`ifdef WBU_INSTRET_EN
    input  logic            minstret_we,
    input  logic [63:0]     minstret_wdata,
    output logic [63:0]     minstret,
`endif
    output logic            load_fault
);
    wbu_state_e state_q, state_d;
    logic [4:0]      ld_rd_q, ld_rd_d;
    logic [XLEN-1:0] ld_pc_q, ld_pc_d;
    logic            rf_we_q, rf_we_d, rf_rel_q, rf_rel_d, csr_we_q, csr_we_d;
    logic            ret_q, ret_d, fault_q, fault_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d, rel_addr_q, rel_addr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d, csr_wdata_q, csr_wdata_d, ret_pc_q, ret_pc_d;
    logic [11:0]     csr_waddr_q, csr_waddr_d;
    logic            tmr_clr, tmr_en, tmr_expired;

    wbu_load_timer #(.LOAD_TIMEOUT(LOAD_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    assign wbu_ready = (state_q == S_IDLE);
    assign tmr_en    = (state_q == S_LOAD_WAIT) && !ram_rvalid;

    always_comb begin
        state_d     = state_q;
        ld_rd_d     = ld_rd_q;
        ld_pc_d     = ld_pc_q;
        rf_we_d     = 1'b0;
        rf_rel_d    = 1'b0;
        csr_we_d    = 1'b0;
        ret_d       = 1'b0;
        fault_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        rel_addr_d  = rel_addr_q;
        csr_waddr_d = csr_waddr_q;
        csr_wdata_d = csr_wdata_q;
        ret_pc_d    = ret_pc_q;
        tmr_clr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (exu_valid) begin
                    if (w_type == WT_LOAD) begin
                        ld_rd_d = rd;
                        ld_pc_d = pc_in;
                        tmr_clr = 1'b1;
                        state_d = S_LOAD_WAIT;
                    end else begin
                        ret_d    = 1'b1;
                        ret_pc_d = pc_in;
                        // Stores and the reserved codes 5..7 only retire.
                        if (w_type == WT_RD || w_type == WT_PC4 || w_type == WT_CSR) begin
                            rf_we_d    = (rd != 5'd0);
                            rf_waddr_d = rd;
                            rf_wdata_d = (w_type == WT_PC4) ? pc_in + 32'd4 : rd_data;
                            rf_rel_d   = 1'b1;
                            rel_addr_d = rd;
                        end
                        if (w_type == WT_CSR) begin
                            csr_we_d    = 1'b1;
                            csr_waddr_d = csr_addr;
                            csr_wdata_d = csr_wdata_in;
                        end
                    end
                end
            end
            S_LOAD_WAIT: begin
                if (ram_rvalid || tmr_expired) begin
                    rf_we_d    = ram_rvalid && (ld_rd_q != 5'd0);
                    rf_waddr_d = ld_rd_q;
                    if (ram_rvalid) rf_wdata_d = ram_rdata;
                    rf_rel_d   = 1'b1;
                    rel_addr_d = ld_rd_q;
                    ret_d      = 1'b1;
                    ret_pc_d   = ld_pc_q;
                    fault_d    = !ram_rvalid;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ld_rd_q     <= '0;
            ld_pc_q     <= '0;
            rf_we_q     <= 1'b0;
            rf_rel_q    <= 1'b0;
            csr_we_q    <= 1'b0;
            ret_q       <= 1'b0;
            fault_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            rel_addr_q  <= '0;
            csr_waddr_q <= '0;
            csr_wdata_q <= '0;
            ret_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            ld_rd_q     <= ld_rd_d;
            ld_pc_q     <= ld_pc_d;
            rf_we_q     <= rf_we_d;
            rf_rel_q    <= rf_rel_d;
            csr_we_q    <= csr_we_d;
            ret_q       <= ret_d;
            fault_q     <= fault_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            rel_addr_q  <= rel_addr_d;
            csr_waddr_q <= csr_waddr_d;
            csr_wdata_q <= csr_wdata_d;
            ret_pc_q    <= ret_pc_d;
        end
    end

    assign rf_we           = rf_we_q;
    assign rf_waddr        = rf_waddr_q;
    assign rf_wdata        = rf_wdata_q;
    assign rf_release      = rf_rel_q;
    assign rf_release_addr = rel_addr_q;
    assign csr_we          = csr_we_q;
    assign csr_waddr       = csr_waddr_q;
    assign csr_wdata       = csr_wdata_q;
    assign retire_valid    = ret_q;
    assign retire_pc       = ret_pc_q;
    assign load_fault      = fault_q;

`ifdef WBU_INSTRET_EN
    logic [63:0] minstret_q;
    // A software write wins over the increment for the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           minstret_q <= '0;
        else if (minstret_we) minstret_q <= minstret_wdata;
        else if (ret_q)       minstret_q <= minstret_q + 64'd1;
    end
    assign minstret = minstret_q;
`endif
endmodule

// File: tb/tb_wbu.sv
// Scoreboard bench for wbu: expectations queued at accept, checked on each retire.
module tb_wbu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        exu_valid = 1'b0;
    logic        wbu_ready;
    logic [31:0] rd_data = '0;
    logic [4:0]  rd = '0;
    logic [31:0] pc_in = '0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata_in = '0;
    logic [2:0]  w_type = '0;
    logic        ram_rvalid = 1'b0;
    logic [31:0] ram_rdata = '0;
    logic        rf_we, rf_release, csr_we, retire_valid, load_fault;
    logic [4:0]  rf_waddr, rf_release_addr;
    logic [31:0] rf_wdata, csr_wdata, retire_pc;
    logic [11:0] csr_waddr;
`ifdef WBU_INSTRET_EN
    logic        minstret_we = 1'b0;
    logic [63:0] minstret_wdata = '0;
    logic [63:0] minstret;
`endif

    int n_vec = 0;
    int n_err = 0;
    int n_ret = 0;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rel;
        logic [4:0]  ra;
        logic        cwe;
        logic [11:0] ca;
        logic [31:0] cd;
        logic [31:0] pc;
        logic        flt;
    } exp_t;
    exp_t sb[$];

    wbu #(.LOAD_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .exu_valid(exu_valid), .wbu_ready(wbu_ready),
        .rd_data(rd_data), .rd(rd), .pc_in(pc_in), .csr_addr(csr_addr),
        .csr_wdata_in(csr_wdata_in), .w_type(w_type), .ram_rvalid(ram_rvalid),
        .ram_rdata(ram_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_release(rf_release), .rf_release_addr(rf_release_addr), .csr_we(csr_we),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .retire_valid(retire_valid),
        .retire_pc(retire_pc),
`ifdef WBU_INSTRET_EN
        .minstret_we(minstret_we), .minstret_wdata(minstret_wdata), .minstret(minstret),
`endif
        .load_fault(load_fault)
    );

    always #5 clk = ~clk;

    // Reference model for a non-load instruction.
    function automatic exp_t model(input logic [2:0] wt, input logic [4:0] r,
                                   input logic [31:0] d, input logic [31:0] pc,
                                   input logic [11:0] ca, input logic [31:0] cw);
        exp_t e;
        logic wr;
        wr    = (wt == 3'd0 || wt == 3'd1 || wt == 3'd4);
        e.we  = wr && (r != 5'd0);
        e.wa  = r;
        e.wd  = (wt == 3'd1) ? pc + 32'd4 : d;
        e.rel = wr;
        e.ra  = r;
        e.cwe = (wt == 3'd4);
        e.ca  = ca;
        e.cd  = cw;
        e.pc  = pc;
        e.flt = 1'b0;
        return e;
    endfunction

    function automatic exp_t load_exp(input logic [4:0] r, input logic [31:0] d,
                                      input logic [31:0] pc, input logic flt);
        exp_t e;
        e = model(3'd0, r, d, pc, 12'h0, 32'h0);
        e.we  = !flt && (r != 5'd0);
        e.flt = flt;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && retire_valid) begin
            exp_t e;
            n_ret++;
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_retire pc=%h", retire_pc);
            end else begin
                e = sb.pop_front();
                if (rf_we !== e.we || rf_release !== e.rel || csr_we !== e.cwe ||
                    load_fault !== e.flt || retire_pc !== e.pc) begin
                    n_err++;
                    $display("FAIL retire_ctl got we=%b rel=%b cwe=%b flt=%b pc=%h want %b %b %b %b %h",
                             rf_we, rf_release, csr_we, load_fault, retire_pc,
                             e.we, e.rel, e.cwe, e.flt, e.pc);
                end
                if (e.we) begin
                    n_vec++;
                    if (rf_waddr !== e.wa || rf_wdata !== e.wd) begin
                        n_err++;
                        $display("FAIL rf_write got %0d/%h want %0d/%h", rf_waddr, rf_wdata, e.wa, e.wd);
                    end
                end
                if (e.rel) begin
                    n_vec++;
                    if (rf_release_addr !== e.ra) begin
                        n_err++;
                        $display("FAIL release_addr got %0d want %0d", rf_release_addr, e.ra);
                    end
                end
                if (e.cwe) begin
                    n_vec++;
                    if (csr_waddr !== e.ca || csr_wdata !== e.cd) begin
                        n_err++;
                        $display("FAIL csr_write got %h/%h want %h/%h", csr_waddr, csr_wdata, e.ca, e.cd);
                    end
                end
            end
        end else if (rst_n && (rf_we || rf_release || csr_we || load_fault)) begin
            n_vec++;
            n_err++;
            $display("FAIL stray_strobe we=%b rel=%b cwe=%b flt=%b", rf_we, rf_release, csr_we, load_fault);
        end
    end

    task automatic send(input logic [2:0] wt, input logic [4:0] r, input logic [31:0] d,
                        input logic [31:0] pc, input logic [11:0] ca, input logic [31:0] cw);
        int t = 0;
        while (!wbu_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (!wbu_ready) begin
            n_vec++; n_err++;
            $display("FAIL ready_timeout got 0 want 1");
        end
        w_type = wt; rd = r; rd_data = d; pc_in = pc; csr_addr = ca; csr_wdata_in = cw;
        exu_valid = 1'b1;
        if (wt != 3'd3) sb.push_back(model(wt, r, d, pc, ca, cw));
        @(posedge clk); #1;
        exu_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        idle(2);
        n_vec++;
        if ({rf_we, rf_waddr, rf_wdata, rf_release, rf_release_addr, csr_we, csr_waddr,
             csr_wdata, retire_valid, retire_pc, load_fault} !== '0 || wbu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state got ready=%b we=%b pc=%h want ready=1 all zero", wbu_ready, rf_we, retire_pc);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_alu();
        send(3'd0, 5'd5, 32'h1234, 32'h100, 12'h0, 32'h0);
        send(3'd0, 5'd0, 32'hDEAD, 32'h104, 12'h0, 32'h0);
        idle(2);
    endtask

    task automatic test_pc4();
        send(3'd1, 5'd1, 32'h0, 32'hFFFF_FFFC, 12'h0, 32'h0);
        send(3'd1, 5'd2, 32'h0, 32'h0000_0200, 12'h0, 32'h0);
        idle(2);
    endtask

    task automatic test_store();
        send(3'd2, 5'd4, 32'h55, 32'h300, 12'h0, 32'h0);
        send(3'd6, 5'd4, 32'h55, 32'h304, 12'h0, 32'h0);
        ram_rvalid = 1'b1; ram_rdata = 32'hBAD0_BAD0;
        idle(2);
        ram_rvalid = 1'b0;
        idle(1);
    endtask

    task automatic test_csr();
        send(3'd4, 5'd0, 32'h77, 32'h400, 12'h300, 32'h8);
        send(3'd4, 5'd9, 32'h1111, 32'h404, 12'h341, 32'hA5A5_0000);
        idle(2);
    endtask

    task automatic test_load();
        send(3'd3, 5'd7, 32'h0, 32'h500, 12'h0, 32'h0);
        sb.push_back(load_exp(5'd7, 32'hCAFE_F00D, 32'h500, 1'b0));
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (wbu_ready !== 1'b0) begin
                n_err++;
                $display("FAIL load_ready_low cycle=%0d got %b want 0", i, wbu_ready);
            end
            if (i == 2) begin ram_rvalid = 1'b1; ram_rdata = 32'hCAFE_F00D; end
            @(posedge clk); #1;
        end
        ram_rvalid = 1'b0;
        n_vec++;
        if (wbu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL load_ready_back got %b want 1", wbu_ready);
        end
        send(3'd0, 5'd8, 32'h8888, 32'h504, 12'h0, 32'h0);
        // rd=0 load: release and retire but no write
        send(3'd3, 5'd0, 32'h0, 32'h508, 12'h0, 32'h0);
        sb.push_back(load_exp(5'd0, 32'h1, 32'h508, 1'b0));
        ram_rvalid = 1'b1; ram_rdata = 32'h1;
        idle(1);
        ram_rvalid = 1'b0;
        idle(2);
    endtask

    task automatic test_timeout();
        int cnt = 0;
        send(3'd3, 5'd9, 32'h0, 32'h600, 12'h0, 32'h0);
        sb.push_back(load_exp(5'd9, 32'h0, 32'h600, 1'b1));
        while (!wbu_ready && cnt < 40) begin
            cnt++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (cnt != 15) begin
            n_err++;
            $display("FAIL timeout_wait got %0d cycles want 15", cnt);
        end
        idle(2);
        // Data arriving on the final wait cycle beats the timeout.
        send(3'd3, 5'd10, 32'h0, 32'h700, 12'h0, 32'h0);
        sb.push_back(load_exp(5'd10, 32'h0BAD_CAFE, 32'h700, 1'b0));
        for (int i = 0; i < 15; i++) begin
            if (i == 14) begin ram_rvalid = 1'b1; ram_rdata = 32'h0BAD_CAFE; end
            @(posedge clk); #1;
        end
        ram_rvalid = 1'b0;
        idle(2);
    endtask

    task automatic test_back_to_back();
        exu_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_type = (i == 1) ? 3'd1 : 3'd0;
            rd = 5'(11 + i); rd_data = 32'h1000 + 32'(i); pc_in = 32'h800 + 32'(4 * i);
            n_vec++;
            if (wbu_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready cycle=%0d got %b want 1", i, wbu_ready);
            end
            sb.push_back(model(w_type, rd, rd_data, pc_in, 12'h0, 32'h0));
            @(posedge clk); #1;
        end
        exu_valid = 1'b0;
        idle(3);
    endtask

    task automatic test_reset_midload();
        send(3'd3, 5'd3, 32'h0, 32'h900, 12'h0, 32'h0);
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({rf_we, rf_waddr, rf_wdata, rf_release, rf_release_addr, csr_we, csr_waddr,
             csr_wdata, retire_valid, retire_pc, load_fault} !== '0 || wbu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset got ready=%b waddr=%0d wdata=%h pc=%h want ready=1 all zero",
                     wbu_ready, rf_waddr, rf_wdata, retire_pc);
        end
        idle(2);
        rst_n = 1'b1;
        ram_rvalid = 1'b1; ram_rdata = 32'h3333;
        idle(2);
        ram_rvalid = 1'b0;
        idle(20);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_pc4();
        test_store();
        test_csr();
        test_load();
        test_timeout();
        test_back_to_back();
        test_reset_midload();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL missing_retires got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
